// File: rtl/exu_mdu.sv
// exu_mdu - iterative RV64M multiply/divide unit for the execute stage.
//
// Accepts one operation through a valid/ready handshake and computes it one
// bit per cycle (radix-2): unsigned shift-add multiply on operand magnitudes,
// and restoring division on magnitudes. Signs are fixed up on the final
// iteration. Division by zero and signed overflow finish straight from the
// accept cycle. The result and the pass-through tag are held on the output
// handshake until taken.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           kills an in-flight or pending operation
//   in_valid/ready  request handshake (ready only while idle)
//   in_op           0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   in_halfop       32-bit W variant with sign-extended result
//   in_src1/2       operands
//   in_tag          destination index, returned as out_tag
//   out_valid/ready result handshake
//   out_result      result
//   out_tag         tag captured at accept
//   busy            unit is not idle
module exu_mdu #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_halfop,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN);
  localparam int SH = XLEN - 32;
  localparam logic HALF_OK = (XLEN == 64);
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MSB_ONLY = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_reg, state_next;

  logic [2:0]        op_reg;
  logic              half_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic              neg_q_reg;   // negate product (mul) or quotient (div)
  logic              neg_r_reg;   // negate remainder
  logic [CW-1:0]     cnt_reg;
  logic [XLEN-1:0]   a_reg;       // multiplier (shifts right) / dividend->quotient (shifts left)
  logic [XLEN-1:0]   b_reg;       // divisor magnitude
  logic [XLEN-1:0]   rem_reg;     // partial remainder
  logic [2*XLEN-1:0] mc_reg;      // multiplicand, shifted left each step
  logic [2*XLEN-1:0] acc_reg;     // product accumulator
  logic [XLEN-1:0]   result_reg;

  // Keep the low 32 bits and extend them back to XLEN.
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] t;
    t = v << SH;
    return sgn ? $unsigned($signed(t) >>> SH) : (t >> SH);
  endfunction

  // ---------------- accept-side decode ----------------
  logic            half_eff, s1_signed, s2_signed, neg1, neg2;
  logic            div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] src1_ext, src2_ext, mag1, mag2, most_neg, special_res;

  always_comb begin
    // W variants exist only for MUL and the divides; MULH* ignore halfop.
    half_eff  = HALF_OK && in_halfop && ((in_op == 3'd0) || in_op[2]);
    s1_signed = in_op[2] ? ~in_op[0] : (in_op != 3'd3);
    s2_signed = in_op[2] ? ~in_op[0] : ~in_op[1];
    src1_ext  = half_eff ? ext32(in_src1, s1_signed) : in_src1;
    src2_ext  = half_eff ? ext32(in_src2, s2_signed) : in_src2;
    neg1      = s1_signed & src1_ext[XLEN-1];
    neg2      = s2_signed & src2_ext[XLEN-1];
    mag1      = neg1 ? -src1_ext : src1_ext;
    mag2      = neg2 ? -src2_ext : src2_ext;
    most_neg  = half_eff ? (ONES << 31) : MSB_ONLY;
    div_zero  = in_op[2] && (src2_ext == '0);
    div_ovf   = in_op[2] && !in_op[0] && (src1_ext == most_neg) && (src2_ext == ONES);
    special   = div_zero || div_ovf;
    if (div_zero) begin
      special_res = in_op[1] ? src1_ext : ONES;
    end else begin
      special_res = in_op[1] ? '0 : src1_ext;
    end
    if (half_eff) begin
      special_res = ext32(special_res, 1'b1);
    end
  end

  // ---------------- one iteration step ----------------
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN:0]     shifted;
  logic              ge;
  logic [XLEN-1:0]   rem_step, quo_step, final_raw, final_res;
  logic              last_iter;

  always_comb begin
    acc_step = acc_reg + (a_reg[0] ? mc_reg : '0);
    prod     = neg_q_reg ? -acc_step : acc_step;
    // Restoring division: bring down the next dividend bit, subtract if it fits.
    shifted  = {rem_reg, a_reg[XLEN-1]};
    ge       = shifted >= {1'b0, b_reg};
    rem_step = ge ? (shifted[XLEN-1:0] - b_reg) : shifted[XLEN-1:0];
    quo_step = {a_reg[XLEN-2:0], ge};
    if (op_reg[2]) begin
      if (op_reg[1]) begin
        final_raw = neg_r_reg ? -rem_step : rem_step;
      end else begin
        final_raw = neg_q_reg ? -quo_step : quo_step;
      end
    end else begin
      final_raw = (op_reg == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
    final_res = half_reg ? ext32(final_raw, 1'b1) : final_raw;
    last_iter = (cnt_reg == (half_reg ? CW'(31) : CW'(XLEN-1)));
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && !flush) begin
          accept     = 1'b1;
          state_next = special ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= '0;
      half_reg   <= 1'b0;
      tag_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      rem_reg    <= '0;
      mc_reg     <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
    end else if (accept) begin
      op_reg    <= in_op;
      half_reg  <= half_eff;
      tag_reg   <= in_tag;
      neg_q_reg <= neg1 ^ neg2;
      neg_r_reg <= neg1;
      cnt_reg   <= '0;
      b_reg     <= mag2;
      rem_reg   <= '0;
      mc_reg    <= {{XLEN{1'b0}}, mag1};
      acc_reg   <= '0;
      // A 32-bit dividend is pre-shifted so its bits leave from the top first.
      if (in_op[2]) begin
        a_reg <= half_eff ? (mag1 << SH) : mag1;
      end else begin
        a_reg <= mag2;
      end
      if (special) begin
        result_reg <= special_res;
      end
    end else if (state_reg == BUSY) begin
      cnt_reg <= cnt_reg + CW'(1);
      acc_reg <= acc_step;
      mc_reg  <= mc_reg << 1;
      rem_reg <= rem_step;
      a_reg   <= op_reg[2] ? quo_step : (a_reg >> 1);
      if (last_iter) begin
        result_reg <= final_res;
      end
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign out_valid  = (state_reg == DONE);
  assign out_result = result_reg;
  assign out_tag    = tag_reg;

endmodule

// File: tb/tb_exu_mdu.sv
// tb_exu_mdu - self-checking bench for exu_mdu (XLEN=64).
// A reference model computes each result with plain 128-bit / signed
// arithmetic; a negedge process compares every cycle's outputs with the
// expected result queue, and directed literal checks pin the model.
module tb_exu_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic        in_halfop = 1'b0;
  logic [63:0] in_src1 = '0;
  logic [63:0] in_src2 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  always #5 clk = ~clk;

  exu_mdu #(.XLEN(64), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_halfop(in_halfop),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          acc;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [63:0] last_res = '0;
  logic [4:0]  last_tag = '0;
  int          last_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the RV64M definitions.
  function automatic logic [63:0] model(input logic [2:0] op, input logic half,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  w;
    int           wa, wb;
    longint       sa, sb;
    logic         ovf;
    wa = a[31:0];
    wb = b[31:0];
    sa = a;
    sb = b;
    w  = '0;
    p  = '0;
    if (half && (op == 3'd0 || op[2])) begin
      ovf = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
      case (op)
        3'd0: w = wa * wb;
        3'd4: begin
          if (wb == 0) w = 32'hFFFF_FFFF;
          else if (ovf) w = a[31:0];
          else w = wa / wb;
        end
        3'd5: begin
          if (wb == 0) w = 32'hFFFF_FFFF;
          else w = a[31:0] / b[31:0];
        end
        3'd6: begin
          if (wb == 0) w = a[31:0];
          else if (ovf) w = '0;
          else w = wa % wb;
        end
        default: begin
          if (wb == 0) w = a[31:0];
          else w = a[31:0] % b[31:0];
        end
      endcase
      return {{32{w[31]}}, w};
    end
    ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    case (op)
      3'd0: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      3'd4: begin
        if (b == 0) return '1;
        if (ovf) return a;
        return sa / sb;
      end
      3'd5: begin
        if (b == 0) return '1;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return '0;
        return sa % sb;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from accept to out_valid.
  function automatic int lat(input logic [2:0] op, input logic half,
                             input logic [63:0] a, input logic [63:0] b);
    logic h;
    h = half && (op == 3'd0 || op[2]);
    if (op[2]) begin
      if (h) begin
        if (b[31:0] == 0 || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF))
          return 1;
      end else if (b == 0 || (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)) begin
        return 1;
      end
    end
    return h ? 33 : 65;
  endfunction

  // Per-cycle compare against the expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      chk1("busy_vs_ready", busy, !in_ready);
      if (q.size() == 0) begin
        chk1("idle_out_valid", out_valid, 1'b0);
        chk1("idle_in_ready", in_ready, 1'b1);
      end else begin
        chk1("in_ready", in_ready, q[0].acc == cyc);
        if (cyc < q[0].due) begin
          chk1("early_out_valid", out_valid, 1'b0);
        end else begin
          chk1("out_valid", out_valid, 1'b1);
          chk("out_result", out_result, q[0].res);
          chk("out_tag", 64'(out_tag), 64'(q[0].tag));
          if (out_valid && out_ready) begin
            last_res = out_result;
            last_tag = out_tag;
            last_lat = cyc - q[0].acc;
            void'(q.pop_front());
          end
        end
      end
      if (flush) q.delete();
    end
  end

  task automatic issue(input logic [2:0] op, input logic half,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_halfop = half;
    in_src1 = a; in_src2 = b; in_tag = tag;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready && !flush && !rst) begin
        e.res = model(op, half, a, b);
        e.tag = tag;
        e.acc = cyc;
        e.due = cyc + lat(op, half, a, b);
        q.push_back(e);
        ok = 1'b1;
      end
    end
    if (!ok) chk1("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_src1 = ~a; in_src2 = ~b; in_tag = ~tag;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && in_ready) ok = 1'b1;
    end
    if (!ok) chk1({name, "_timeout"}, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        half;
    logic [63:0] a;
    logic [63:0] b;
  } vec_t;

  vec_t vecs[16] = '{
    '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3},
    '{3'd1, 1'b0, 64'h4000_0000_0000_0000, 64'd4},
    '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000},
    '{3'd5, 1'b0, 64'd100, 64'd7},
    '{3'd7, 1'b0, 64'd100, 64'd7},
    '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7},
    '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7},
    '{3'd4, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9},
    '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2},
    '{3'd5, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2},
    '{3'd7, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2},
    '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF},
    '{3'd5, 1'b1, 64'd9, 64'hABCD_0000_0000_0000},
    '{3'd6, 1'b1, 64'h0000_0000_8000_0001, 64'd0},
    '{3'd3, 1'b1, 64'hDEAD_BEEF_0123_4567, 64'h0FED_CBA9_8765_4321},
    '{3'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}
  };

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);

    // Literal pins for the model itself.
    chk("model_mul", model(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("model_mulhu", model(3'd3, 1'b0, '1, '1), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("model_mulh", model(3'd1, 1'b0, '1, '1), 64'd0);
    chk("model_div0", model(3'd4, 1'b0, 64'd5, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model_rem0", model(3'd6, 1'b0, 64'd5, 64'd0), 64'd5);
    chk("model_divw", model(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_remw", model(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model_divu", model(3'd5, 1'b0, 64'd100, 64'd7), 64'd14);

    // Directed DUT vectors with literal results and latencies.
    issue(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9);
    wait_done("mul");
    chk("mul_result", last_res, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_latency", 64'(last_lat), 64'd65);
    chk("mul_tag", 64'(last_tag), 64'd9);

    issue(3'd3, 1'b0, '1, '1, 5'd1);
    wait_done("mulhu");
    chk("mulhu_result", last_res, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(3'd1, 1'b0, '1, '1, 5'd2);
    wait_done("mulh");
    chk("mulh_result", last_res, 64'd0);

    issue(3'd4, 1'b0, 64'd5, 64'd0, 5'd3);
    wait_done("div0");
    chk("div0_result", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("div0_latency", 64'(last_lat), 64'd1);
    issue(3'd6, 1'b0, 64'd5, 64'd0, 5'd4);
    wait_done("rem0");
    chk("rem0_result", last_res, 64'd5);
    chk("rem0_latency", 64'(last_lat), 64'd1);

    issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd5);
    wait_done("divovf");
    chk("divovf_result", last_res, 64'h8000_0000_0000_0000);
    issue(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd6);
    wait_done("removf");
    chk("removf_result", last_res, 64'd0);

    issue(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd7);
    wait_done("divw");
    chk("divw_result", last_res, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("divw_latency", 64'(last_lat), 64'd33);
    issue(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd8);
    wait_done("remw");
    chk("remw_result", last_res, 64'hFFFF_FFFF_FFFF_FFFF);

    // Back-to-back table: in_valid stays high through DONE, checked by the model.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].half, vecs[i].a, vecs[i].b, 5'(i + 10));
    end
    wait_done("table");

    // Hold the result for several cycles with out_ready low.
    out_ready = 1'b0;
    issue(3'd2, 1'b0, 64'h8000_0000_0000_0001, 64'hFFFF_0000_FFFF_0000, 5'd17);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      if (!seen) chk1("hold_valid_timeout", 1'b0, 1'b1);
    end
    repeat (5) @(negedge clk);
    chk1("hold_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("hold");
    chk("hold_tag", 64'(last_tag), 64'd17);

    // Flush in cycle 10 of a MUL: no result, idle right after.
    issue(3'd0, 1'b0, 64'd12345, 64'd678, 5'd20);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk1("flush_in_ready", in_ready, 1'b1);
    chk1("flush_out_valid", out_valid, 1'b0);
    repeat (80) @(negedge clk);

    // Reset in the middle of a DIV.
    issue(3'd4, 1'b0, 64'd1000, 64'd7, 5'd3);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk("midrst_out_result", out_result, 64'd0);
    chk("midrst_out_tag", 64'(out_tag), 64'd0);
    repeat (70) @(negedge clk);

    issue(3'd5, 1'b0, 64'd1000, 64'd7, 5'd31);
    wait_done("after_rst");
    chk("after_rst_result", last_res, 64'd142);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
